sprite_motion_ctrl: RTL and testbench

//  Parametrised position controller for one game sprite (Pac-Man or ghost) on the 640x480 VGA field.

---
 rtl/sprite_motion_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// Position controller for one sprite on the VGA field: keypad/PS/2 direction commands,
// step or tick-paced continuous motion, clamping to a programmable box with wall-hit pulse.
module sprite_motion_ctrl #(
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 608,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 448,
    parameter int X_INIT      = 30,
    parameter int Y_INIT      = 146,
    parameter int STEP_CMD    = 20,
    parameter int STEP_RUN    = 1,
    parameter int TICK_CYCLES = 250000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           mode,
    input  logic           key_ready,
    input  logic [4:0]     key_code,
    input  logic           ps2_ready,
    input  logic [7:0]     ps2_code,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic [1:0]     dir,
    output logic           moving,
    output logic           hit_wall
);
    localparam int CW = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);
    localparam logic signed [X_W:0] XMIN_S = (X_W+1)'(X_MIN);
    localparam logic signed [X_W:0] XMAX_S = (X_W+1)'(X_MAX);
    localparam logic signed [Y_W:0] YMIN_S = (Y_W+1)'(Y_MIN);
    localparam logic signed [Y_W:0] YMAX_S = (Y_W+1)'(Y_MAX);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e         state_q;
    logic [X_W-1:0] pos_x_q;
    logic [Y_W-1:0] pos_y_q;
    logic [1:0]     dir_q, pend_q;
    logic           pend_v_q, hit_q;
    logic           key_hist_q, ps2_hist_q, mode_q;
    logic [CW-1:0]  tick_cnt_q;

    logic           key_hit, ps2_hit, key_v, ps2_v, cmd_v, tick;
    logic [1:0]     key_dir, ps2_dir, cmd_dir;
    logic [1:0]     dir_a, pend_a, tick_dir, mv_dir;
    logic           pend_v_a, clamp;
    logic signed [X_W:0] sx, stx;
    logic signed [Y_W:0] sy, sty;
    logic [X_W-1:0] pos_x_d;
    logic [Y_W-1:0] pos_y_d;

    always_comb begin
        key_hit = 1'b1;
        key_dir = 2'd0;
        case (key_code)
            5'h0E:   key_dir = 2'd0;
            5'h0C:   key_dir = 2'd1;
            5'h09:   key_dir = 2'd2;
            5'h11:   key_dir = 2'd3;
            default: key_hit = 1'b0;
        endcase
        ps2_hit = 1'b1;
        ps2_dir = 2'd0;
        case (ps2_code)
            8'h74:   ps2_dir = 2'd0;
            8'h6B:   ps2_dir = 2'd1;
            8'h75:   ps2_dir = 2'd2;
            8'h72:   ps2_dir = 2'd3;
            default: ps2_hit = 1'b0;
        endcase
        key_v   = key_ready & ~key_hist_q & key_hit;
        ps2_v   = ps2_ready & ~ps2_hist_q & ps2_hit;
        cmd_v   = key_v | ps2_v;
        cmd_dir = key_v ? key_dir : ps2_dir;
        tick    = en && (mode == mode_q) && (tick_cnt_q == TICK_LAST);
    end

    // RUN: a command lands in pending first (opposite heading bypasses it), then a tick consumes it.
    always_comb begin
        dir_a    = dir_q;
        pend_a   = pend_q;
        pend_v_a = pend_v_q;
        if (cmd_v) begin
            if (cmd_dir == (dir_q ^ 2'd1)) begin
                dir_a    = cmd_dir;
                pend_v_a = 1'b0;
            end else begin
                pend_a   = cmd_dir;
                pend_v_a = 1'b1;
            end
        end
        tick_dir = pend_v_a ? pend_a : dir_a;
        mv_dir   = mode ? tick_dir : cmd_dir;
    end

    always_comb begin
        stx   = mode ? (X_W+1)'(STEP_RUN) : (X_W+1)'(STEP_CMD);
        sty   = mode ? (Y_W+1)'(STEP_RUN) : (Y_W+1)'(STEP_CMD);
        sx    = $signed({1'b0, pos_x_q});
        sy    = $signed({1'b0, pos_y_q});
        clamp = 1'b0;
        case (mv_dir)
            2'd0: sx = sx + stx;
            2'd1: sx = sx - stx;
            2'd2: sy = sy - sty;
            2'd3: sy = sy + sty;
            default: ;
        endcase
        if (sx < XMIN_S) begin
            sx    = XMIN_S;
            clamp = 1'b1;
        end else if (sx > XMAX_S) begin
            sx    = XMAX_S;
            clamp = 1'b1;
        end
        if (sy < YMIN_S) begin
            sy    = YMIN_S;
            clamp = 1'b1;
        end else if (sy > YMAX_S) begin
            sy    = YMAX_S;
            clamp = 1'b1;
        end
        pos_x_d = sx[X_W-1:0];
        pos_y_d = sy[Y_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pos_x_q    <= X_W'(X_INIT);
            pos_y_q    <= Y_W'(Y_INIT);
            dir_q      <= 2'd0;
            pend_q     <= 2'd0;
            pend_v_q   <= 1'b0;
            hit_q      <= 1'b0;
            key_hist_q <= 1'b0;
            ps2_hist_q <= 1'b0;
            mode_q     <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            key_hist_q <= key_ready;
            ps2_hist_q <= ps2_ready;
            mode_q     <= mode;
            hit_q      <= 1'b0;
            if (mode != mode_q)
                tick_cnt_q <= '0;
            else if (en)
                tick_cnt_q <= tick ? '0 : tick_cnt_q + CW'(1);

            if (!mode) begin
                state_q  <= S_IDLE;
                pend_v_q <= 1'b0;
                if (en && cmd_v) begin
                    dir_q   <= cmd_dir;
                    pos_x_q <= pos_x_d;
                    pos_y_q <= pos_y_d;
                    hit_q   <= clamp;
                end
            end else if (en) begin
                case (state_q)
                    S_IDLE: begin
                        if (cmd_v) begin
                            dir_q    <= cmd_dir;
                            pend_v_q <= 1'b0;
                            state_q  <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        dir_q    <= dir_a;
                        pend_q   <= pend_a;
                        pend_v_q <= pend_v_a;
                        if (tick) begin
                            dir_q    <= tick_dir;
                            pend_v_q <= 1'b0;
                            pos_x_q  <= pos_x_d;
                            pos_y_q  <= pos_y_d;
                            if (clamp) begin
                                hit_q   <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign dir      = dir_q;
    assign moving   = (state_q == S_RUN);
    assign hit_wall = hit_q;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with TICK_CYCLES=4; expected values are hand-derived.
module tb_sprite_motion_ctrl;
    logic       clk = 1'b0;
    logic       rst, en, mode, key_ready, ps2_ready;
    logic [4:0] key_code;
    logic [7:0] ps2_code;
    logic [9:0] pos_x;
    logic [8:0] pos_y;
    logic [1:0] dir;
    logic       moving, hit_wall;

    int passed = 0;
    int total  = 0;

    sprite_motion_ctrl #(.TICK_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .key_ready(key_ready), .key_code(key_code),
        .ps2_ready(ps2_ready), .ps2_code(ps2_code),
        .pos_x(pos_x), .pos_y(pos_y), .dir(dir),
        .moving(moving), .hit_wall(hit_wall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Rising edge seen at the next posedge; ready drops before the following one.
    task automatic press_key(input logic [4:0] code);
        key_code  = code;
        key_ready = 1'b1;
        cyc();
        key_ready = 1'b0;
    endtask

    task automatic press_ps2(input logic [7:0] code);
        ps2_code  = code;
        ps2_ready = 1'b1;
        cyc();
        ps2_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b0; en = 1'b1; mode = 1'b0;
        key_ready = 1'b0; ps2_ready = 1'b0; key_code = '0; ps2_code = '0;
        cyc(); cyc();
        rst = 1'b1;
        check("rst_x", pos_x, 30);
        check("rst_y", pos_y, 146);
        check("rst_dir", dir, 0);
        check("rst_moving", moving, 0);
        check("rst_hit", hit_wall, 0);

        press_key(5'h0E);
        check("step_r_x", pos_x, 50);
        check("step_r_y", pos_y, 146);
        check("step_r_dir", dir, 0);
        check("step_r_hit", hit_wall, 0);
        cyc();

        press_ps2(8'h6B); cyc();
        press_ps2(8'h6B);
        check("step_l_x10", pos_x, 10);
        check("step_l_dir", dir, 1);
        cyc();
        press_ps2(8'h6B);
        check("clamp_x0", pos_x, 0);
        check("clamp_hit", hit_wall, 1);
        cyc();
        check("clamp_hit_drop", hit_wall, 0);
        press_ps2(8'h6B);
        check("bound_x0", pos_x, 0);
        check("bound_hit", hit_wall, 1);
        cyc();
        check("bound_hit_drop", hit_wall, 0);

        key_code = 5'h09; ps2_code = 8'h74;
        key_ready = 1'b1; ps2_ready = 1'b1;
        cyc();
        key_ready = 1'b0; ps2_ready = 1'b0;
        check("both_y", pos_y, 126);
        check("both_x", pos_x, 0);
        check("both_dir", dir, 2);
        cyc();

        key_code = 5'h11; key_ready = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        key_ready = 1'b0;
        check("held_y", pos_y, 146);
        check("held_dir", dir, 3);
        cyc();

        press_key(5'h05);
        check("unlisted_y", pos_y, 146);
        check("unlisted_dir", dir, 3);
        cyc();

        mode = 1'b1;
        cyc(); cyc();
        press_key(5'h11);
        check("run_enter_moving", moving, 1);
        check("run_enter_dir", dir, 3);
        check("run_enter_y", pos_y, 146);
        n = 0;
        while (pos_y == 9'd146 && n < 10) begin cyc(); n++; end
        check("run_first_y", pos_y, 147);
        n = 0;
        do begin cyc(); n++; end while (pos_y == 9'd147 && n < 10);
        check("run_period", n, 4);
        check("run_second_y", pos_y, 148);
        n = 0;
        while (pos_y != 9'd448 && n < 2000) begin cyc(); n++; end
        check("run_reach_y", pos_y, 448);
        check("run_reach_hit", hit_wall, 0);
        n = 0;
        do begin cyc(); n++; end while (!hit_wall && n < 10);
        check("wall_period", n, 4);
        check("wall_hit", hit_wall, 1);
        check("wall_moving", moving, 0);
        check("wall_y", pos_y, 448);
        cyc();
        check("wall_hit_drop", hit_wall, 0);

        press_key(5'h0E);
        check("right_moving", moving, 1);
        n = 0;
        while (pos_x == 10'd0 && n < 10) begin cyc(); n++; end
        check("right_x", pos_x, 1);
        press_ps2(8'h75);
        check("pend_dir_hold", dir, 0);
        n = 0;
        while (pos_y == 9'd448 && n < 10) begin cyc(); n++; end
        check("pend_dir_applied", dir, 2);
        check("pend_y", pos_y, 447);
        check("pend_x", pos_x, 1);
        press_key(5'h0E);
        n = 0;
        while (pos_x == 10'd1 && n < 10) begin cyc(); n++; end
        check("back_right_dir", dir, 0);
        check("back_right_x", pos_x, 2);
        press_key(5'h0C);
        check("reverse_dir", dir, 1);
        check("reverse_x", pos_x, 2);

        mode = 1'b0;
        cyc();
        check("mode_drop_moving", moving, 0);
        check("mode_drop_x", pos_x, 2);
        mode = 1'b1;
        cyc(); cyc();
        press_key(5'h11);
        check("rerun_moving", moving, 1);

        rst = 1'b0;
        cyc();
        rst = 1'b1;
        check("midrst_x", pos_x, 30);
        check("midrst_y", pos_y, 146);
        check("midrst_dir", dir, 0);
        check("midrst_moving", moving, 0);

        cyc();
        press_key(5'h0E);
        en = 1'b0;
        check("en_run_moving", moving, 1);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) press_ps2(8'h72);
            else cyc();
        end
        check("en_hold_x", pos_x, 30);
        check("en_hold_y", pos_y, 146);
        check("en_hold_dir", dir, 0);
        check("en_hold_moving", moving, 1);
        en = 1'b1;
        n = 0;
        while (pos_x == 10'd30 && n < 10) begin cyc(); n++; end
        check("en_resume_x", pos_x, 31);
        check("en_resume_y", pos_y, 146);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
